// File: rtl/ifft16_pkg.sv
// rtl/ifft16_pkg.sv - shared constants, twiddle table, state type and helpers for the 16-point serial IFFT
package ifft16_pkg;

  localparam int DW    = 16;
  localparam int TW    = 16;
  localparam int N     = 16;
  localparam int LOG2N = 4;

  // Inverse-direction twiddles W = cos + j*sin, Q1.14
  localparam logic signed [TW-1:0] TW_COS [8] = '{
    16'sd16384, 16'sd15137, 16'sd11585, 16'sd6270,
    16'sd0, -16'sd6270, -16'sd11585, -16'sd15137
  };
  localparam logic signed [TW-1:0] TW_SIN [8] = '{
    16'sd0, 16'sd6270, 16'sd11585, 16'sd15137,
    16'sd16384, 16'sd15137, 16'sd11585, 16'sd6270
  };

  typedef enum logic [1:0] {
    LOAD,
    COMPUTE,
    UNLOAD
  } state_t;

  function automatic logic [3:0] bitrev4(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

endpackage

// File: rtl/ifft_butterfly.sv
// rtl/ifft_butterfly.sv - combinational radix-2 DIT butterfly with rounding, halving and saturation
module ifft_butterfly
  import ifft16_pkg::*;
(
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_im,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_im,
  input  logic signed [TW-1:0] w_re,
  input  logic signed [TW-1:0] w_im,
  output logic signed [DW-1:0] x_re,
  output logic signed [DW-1:0] x_im,
  output logic signed [DW-1:0] y_re,
  output logic signed [DW-1:0] y_im
);

  localparam int PW   = 34;
  localparam int SW   = 35;
  localparam int FRAC = TW - 2;

  localparam logic signed [PW-1:0] RND  = PW'(1) <<< (FRAC - 1);
  localparam logic signed [SW-1:0] MAXV = 35'sd32767;
  localparam logic signed [SW-1:0] MINV = -35'sd32768;

  function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > MAXV) return 16'sh7fff;
    if (v < MINV) return 16'sh8000;
    return v[DW-1:0];
  endfunction

  logic signed [PW-1:0] br_x, bi_x, wr_x, wi_x, p_re, p_im;
  logic signed [SW-1:0] ar_x, ai_x, s_re, s_im, d_re, d_im;

  always_comb begin
    br_x = PW'(b_re);
    bi_x = PW'(b_im);
    wr_x = PW'(w_re);
    wi_x = PW'(w_im);
    p_re = (br_x * wr_x - bi_x * wi_x + RND) >>> FRAC;
    p_im = (br_x * wi_x + bi_x * wr_x + RND) >>> FRAC;
    ar_x = SW'(a_re);
    ai_x = SW'(a_im);
    // the per-stage halving supplies the 1/N scaling over four stages
    s_re = (ar_x + SW'(p_re)) >>> 1;
    s_im = (ai_x + SW'(p_im)) >>> 1;
    d_re = (ar_x - SW'(p_re)) >>> 1;
    d_im = (ai_x - SW'(p_im)) >>> 1;
    x_re = sat(s_re);
    x_im = sat(s_im);
    y_re = sat(d_re);
    y_im = sat(d_im);
  end

endmodule

// File: rtl/ifft_radix2_16_serial.sv
// rtl/ifft_radix2_16_serial.sv - serial-in/serial-out 16-point radix-2 DIT inverse FFT, one butterfly per cycle
module ifft_radix2_16_serial
  import ifft16_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_real,
  input  logic signed [DW-1:0] in_imag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_real,
  output logic signed [DW-1:0] out_imag,
  output logic                 out_last,
  output logic                 busy
);

  localparam logic [LOG2N:0] LAST_BIN = (LOG2N + 1)'(N - 1);
  localparam logic [LOG2N:0] LAST_BFY = (LOG2N + 1)'((N / 2) * LOG2N - 1);

  state_t         state, state_nxt;
  logic [LOG2N:0] cnt, cnt_nxt;
  logic           load_we, bf_we;

  logic signed [DW-1:0] rf_re [N];
  logic signed [DW-1:0] rf_im [N];

  logic [1:0] stage;
  logic [2:0] j;
  logic [3:0] addr_a, addr_b;
  logic [2:0] tw_idx;
  logic signed [DW-1:0] x_re, x_im, y_re, y_im;

  assign stage = cnt[4:3];
  assign j     = cnt[2:0];

  // a is j with a zero bit inserted at position s; t = pos * (8 >> s)
  always_comb begin
    addr_a = '0;
    tw_idx = '0;
    unique case (stage)
      2'd0: begin addr_a = {j, 1'b0};              tw_idx = 3'd0;            end
      2'd1: begin addr_a = {j[2:1], 1'b0, j[0]};   tw_idx = {j[0], 2'b00};   end
      2'd2: begin addr_a = {j[2], 1'b0, j[1:0]};   tw_idx = {j[1:0], 1'b0};  end
      default: begin addr_a = {1'b0, j};           tw_idx = j;               end
    endcase
  end

  assign addr_b = addr_a | (4'd1 << stage);

  ifft_butterfly u_bfly (
    .a_re (rf_re[addr_a]),
    .a_im (rf_im[addr_a]),
    .b_re (rf_re[addr_b]),
    .b_im (rf_im[addr_b]),
    .w_re (TW_COS[tw_idx]),
    .w_im (TW_SIN[tw_idx]),
    .x_re (x_re),
    .x_im (x_im),
    .y_re (y_re),
    .y_im (y_im)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load_we   = 1'b0;
    bf_we     = 1'b0;
    unique case (state)
      LOAD: begin
        in_ready = rst;
        if (in_valid && in_ready) begin
          load_we = 1'b1;
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST_BIN) begin
            state_nxt = COMPUTE;
            cnt_nxt   = '0;
          end
        end
      end
      COMPUTE: begin
        busy    = 1'b1;
        bf_we   = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_BFY) begin
          state_nxt = UNLOAD;
          cnt_nxt   = '0;
        end
      end
      default: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == LAST_BIN) begin
            state_nxt = LOAD;
            cnt_nxt   = '0;
          end
        end
      end
    endcase
  end

  assign out_last = out_valid && (cnt[3:0] == 4'd15);
  assign out_real = out_valid ? rf_re[cnt[3:0]] : '0;
  assign out_imag = out_valid ? rf_im[cnt[3:0]] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= LOAD;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // storage contents are don't-care after reset, so the file carries no reset
  always_ff @(posedge clk) begin
    if (load_we) begin
      rf_re[bitrev4(cnt[3:0])] <= in_real;
      rf_im[bitrev4(cnt[3:0])] <= in_imag;
    end
    if (bf_we) begin
      rf_re[addr_a] <= x_re;
      rf_im[addr_a] <= x_im;
      rf_re[addr_b] <= y_re;
      rf_im[addr_b] <= y_im;
    end
  end

endmodule

// File: tb/tb_ifft_radix2_16_serial.sv
// tb/tb_ifft_radix2_16_serial.sv - self-checking bench for the 16-point serial IFFT against a textbook reference model
module tb_ifft_radix2_16_serial;

  localparam real PI = 3.14159265358979;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_real, in_imag;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_real, out_imag;
  logic               out_last;
  logic               busy;

  int n_checks = 0;
  int n_fails  = 0;

  int wc [8];
  int ws [8];
  int in_r [16], in_i [16];
  int exp_r [16], exp_i [16];
  int got_r [16], got_i [16];

  ifft_radix2_16_serial dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int idx, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s[%0d]: observed %0d expected %0d", tag, idx, obs, exp);
    end
  endtask

  function automatic int brev(input int k);
    int r = 0;
    for (int b = 0; b < 4; b++)
      if (((k >> b) & 1) != 0) r |= 1 << (3 - b);
    return r;
  endfunction

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Textbook in-place DIT: bit-reversed load, then groups of size 2h per stage
  task automatic ref_model();
    longint xr [16], xi [16];
    longint ar, ai, br, bi, pr, pim;
    int h, t, ia, ib;
    for (int k = 0; k < 16; k++) begin
      xr[brev(k)] = in_r[k];
      xi[brev(k)] = in_i[k];
    end
    for (int s = 0; s < 4; s++) begin
      h = 1 << s;
      for (int g = 0; g < 16; g += 2 * h) begin
        for (int k = 0; k < h; k++) begin
          t  = k * 16 / (2 * h);
          ia = g + k;
          ib = g + k + h;
          ar = xr[ia]; ai = xi[ia];
          br = xr[ib]; bi = xi[ib];
          pr  = (br * wc[t] - bi * ws[t] + 8192) >>> 14;
          pim = (br * ws[t] + bi * wc[t] + 8192) >>> 14;
          xr[ia] = sat16((ar + pr) >>> 1);
          xi[ia] = sat16((ai + pim) >>> 1);
          xr[ib] = sat16((ar - pr) >>> 1);
          xi[ib] = sat16((ai - pim) >>> 1);
        end
      end
    end
    for (int n = 0; n < 16; n++) begin
      exp_r[n] = int'(xr[n]);
      exp_i[n] = int'(xi[n]);
    end
  endtask

  // bub: 0 none, 1 every other cycle, 2 random; abort_at > 0 resets after that many compute edges
  task automatic run_frame(input int bub, input bit toggle, input int abort_at);
    int lat;
    bit gap;
    ref_model();
    for (int k = 0; k < 16; k++) begin
      gap = (bub == 1 && k > 0) || (bub == 2 && $urandom_range(0, 1) == 1);
      if (gap) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_real  = 16'(in_r[k]);
      in_imag  = 16'(in_i[k]);
      lat = 0;
      while (!in_ready && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("in_ready_load", k, 32'(in_ready), 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_real  = '0;
    in_imag  = '0;

    lat = 0;
    while (!out_valid && lat < 100) begin
      chk("in_ready_compute", lat, 32'(in_ready), 0);
      if (abort_at > 0 && lat == abort_at) begin
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_out_valid", 0, 32'(out_valid), 0);
        chk("abort_busy", 0, 32'(busy), 0);
        chk("abort_in_ready", 0, 32'(in_ready), 0);
        chk("abort_out_re", 0, 32'(out_real), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_in_ready_rel", 0, 32'(in_ready), 1);
        chk("abort_out_valid_rel", 0, 32'(out_valid), 0);
        return;
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 0, lat, 32);

    for (int n = 0; n < 16; n++) begin
      chk("out_valid", n, 32'(out_valid), 1);
      chk("busy_unload", n, 32'(busy), 1);
      chk("in_ready_unload", n, 32'(in_ready), 0);
      if (toggle) begin
        out_ready = 1'b0;
        chk("pre_stall_re", n, 32'(out_real), exp_r[n]);
        @(posedge clk); #1;
        chk("stall_valid", n, 32'(out_valid), 1);
        chk("stall_re", n, 32'(out_real), exp_r[n]);
        chk("stall_im", n, 32'(out_imag), exp_i[n]);
        out_ready = 1'b1;
      end
      got_r[n] = int'(out_real);
      got_i[n] = int'(out_imag);
      chk("out_last", n, 32'(out_last), (n == 15) ? 1 : 0);
      chk("out_re", n, got_r[n], exp_r[n]);
      chk("out_im", n, got_i[n], exp_i[n]);
      @(posedge clk); #1;
    end
    chk("in_ready_after", 0, 32'(in_ready), 1);
    chk("busy_after", 0, 32'(busy), 0);
    chk("out_valid_after", 0, 32'(out_valid), 0);
  endtask

  task automatic set_impulse(input int amp);
    for (int k = 0; k < 16; k++) begin
      in_r[k] = 0;
      in_i[k] = 0;
    end
    in_r[0] = amp;
  endtask

  initial begin
    int ir, ii;
    for (int t = 0; t < 8; t++) begin
      wc[t] = $rtoi($floor(16384.0 * $cos(2.0 * PI * t / 16.0) + 0.5));
      ws[t] = $rtoi($floor(16384.0 * $sin(2.0 * PI * t / 16.0) + 0.5));
    end

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_real   = '0;
    in_imag   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 0, 32'(out_valid), 0);
    chk("rst_out_last", 0, 32'(out_last), 0);
    chk("rst_busy", 0, 32'(busy), 0);
    chk("rst_in_ready", 0, 32'(in_ready), 0);
    chk("rst_out_re", 0, 32'(out_real), 0);
    chk("rst_out_im", 0, 32'(out_imag), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 0, 32'(in_ready), 1);

    // impulse
    set_impulse(16384);
    run_frame(0, 1'b0, 0);
    for (int n = 0; n < 16; n++) begin
      chk("imp_re", n, got_r[n], 1024);
      chk("imp_im", n, got_i[n], 0);
    end

    // DC spectrum with 1,0,1,0 backpressure
    for (int k = 0; k < 16; k++) begin
      in_r[k] = 1600;
      in_i[k] = 0;
    end
    run_frame(0, 1'b1, 0);
    for (int n = 0; n < 16; n++) begin
      chk("dc_re", n, got_r[n], (n == 0) ? 1600 : 0);
      chk("dc_im", n, got_i[n], 0);
    end

    // single tone on bin 1
    set_impulse(0);
    in_r[1] = 16384;
    run_frame(0, 1'b0, 0);
    chk("tone0_re", 0, got_r[0], 1024);
    chk("tone0_im", 0, got_i[0], 0);
    chk("tone4_re", 4, got_r[4], 0);
    chk("tone4_im", 4, got_i[4], 1024);
    chk("tone8_re", 8, got_r[8], -1024);
    chk("tone8_im", 8, got_i[8], 0);
    for (int n = 0; n < 16; n++) begin
      ir = $rtoi($floor(1024.0 * $cos(2.0 * PI * n / 16.0) + 0.5));
      ii = $rtoi($floor(1024.0 * $sin(2.0 * PI * n / 16.0) + 0.5));
      chk("tone_err_re", n, ((got_r[n] - ir <= 2) && (ir - got_r[n] <= 2)) ? 1 : 0, 1);
      chk("tone_err_im", n, ((got_i[n] - ii <= 2) && (ii - got_i[n] <= 2)) ? 1 : 0, 1);
    end

    // reset mid-compute, then a fresh impulse frame
    set_impulse(16384);
    run_frame(0, 1'b0, 10);
    run_frame(0, 1'b0, 0);
    for (int n = 0; n < 16; n++)
      chk("post_abort_re", n, got_r[n], 1024);

    // full-scale input with bubbles every other cycle
    for (int k = 0; k < 16; k++) begin
      in_r[k] = 32767;
      in_i[k] = 32767;
    end
    run_frame(1, 1'b0, 0);
    chk("sat0_re", 0, got_r[0], 32767);
    chk("sat0_im", 0, got_i[0], 32767);

    // back-to-back random frames, random bubbles, alternating backpressure
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 16; k++) begin
        in_r[k] = int'($signed(16'($urandom)));
        in_i[k] = int'($signed(16'($urandom)));
      end
      run_frame(2, f[0], 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
